// File: rtl/regfile_pkg.sv
// Shared constants and requester encoding for the register-file writeback path.
package regfile_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the source not granted last wins a tie.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_alu,
    input  logic req_lsu,
    input  logic done,
    output logic gnt_alu,
    output logic gnt_lsu
);

    src_e last_grant;

    always_comb begin
        gnt_alu = req_alu & (~req_lsu | (last_grant == SRC_LSU));
        gnt_lsu = req_lsu & (~req_alu | (last_grant == SRC_ALU));
    end

    // Reset to LSU so the ALU wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= SRC_LSU;
        end else if (done) begin
            last_grant <= gnt_alu ? SRC_ALU : SRC_LSU;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback arbiter, per-register busy scoreboard and registered write port
// feeding register_file.
module regfile_wb_ctrl #(
    parameter int unsigned XLEN = regfile_pkg::XLEN,
    parameter int unsigned NREG = regfile_pkg::NREG,
    parameter int unsigned AW   = regfile_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    output logic            issue_stall,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic [AW-1:0]   A3,
    output logic [XLEN-1:0] WD3,
    output logic            WE3,
    output logic            idle
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] busy_next;
    logic            wr_fire;
    logic [AW-1:0]   wr_rd;
    logic [XLEN-1:0] wr_data;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_alu (alu_valid),
        .req_lsu (lsu_valid),
        .done    (wr_fire),
        .gnt_alu (alu_ready),
        .gnt_lsu (lsu_ready)
    );

    assign wr_fire     = alu_ready | lsu_ready;
    assign issue_stall = issue_valid & (busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]);
    assign idle        = ~(|busy) & ~WE3;

    always_comb begin
        wr_rd   = alu_ready ? alu_rd   : lsu_rd;
        wr_data = alu_ready ? alu_data : lsu_data;
    end

    // Clear is applied before set so a same-index collision leaves the bit set.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && !issue_stall && (issue_rd != '0)) begin
            set_vec[issue_rd] = 1'b1;
        end
        if (WE3) begin
            clr_vec[A3] = 1'b1;
        end
        busy_next    = (busy & ~clr_vec) | set_vec;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            A3   <= '0;
            WD3  <= '0;
            WE3  <= 1'b0;
        end else begin
            busy <= busy_next;
            WE3  <= wr_fire & (wr_rd != '0);
            if (wr_fire) begin
                A3  <= wr_rd;
                WD3 <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl.
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic        idle;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_ctrl #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_stall (issue_stall),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .A3          (A3),
        .WD3         (WD3),
        .WE3         (WE3),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        n_checks++; if (WE3 !== 1'b0) begin n_fail++; $display("FAIL reset_we3: got %b expected 0", WE3); end
        n_checks++; if (A3 !== 5'd0) begin n_fail++; $display("FAIL reset_a3: got %0d expected 0", A3); end
        n_checks++; if (WD3 !== 32'h0) begin n_fail++; $display("FAIL reset_wd3: got %h expected 0", WD3); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (WE3 !== 1'b0) begin n_fail++; $display("FAIL release_we3: got %b expected 0", WE3); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL release_idle: got %b expected 1", idle); end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h1234_5678;
        #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_alu_ready: got %b expected 1", alu_ready); end
        n_checks++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL single_lsu_ready: got %b expected 0", lsu_ready); end
        @(posedge clk); #1;
        n_checks++; if (A3 !== 5'd2) begin n_fail++; $display("FAIL single_a3: got %0d expected 2", A3); end
        n_checks++; if (WD3 !== 32'h1234_5678) begin n_fail++; $display("FAIL single_wd3: got %h expected 12345678", WD3); end
        n_checks++; if (WE3 !== 1'b1) begin n_fail++; $display("FAIL single_we3: got %b expected 1", WE3); end
        @(negedge clk);
        alu_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (WE3 !== 1'b0) begin n_fail++; $display("FAIL single_we3_drop: got %b expected 0", WE3); end
        n_checks++; if (A3 !== 5'd2 || WD3 !== 32'h1234_5678) begin n_fail++; $display("FAIL single_hold: got a3=%0d wd3=%h expected a3=2 wd3=12345678", A3, WD3); end
    endtask

    // Last handshake was ALU, so the first tie goes to LSU.
    task automatic test_round_robin();
        logic exp_alu;
        exp_alu = 1'b0;
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA1A1_0003;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hB2B2_0004;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (alu_ready !== exp_alu || lsu_ready !== !exp_alu) begin n_fail++; $display("FAIL rr_grant[%0d]: got alu=%b lsu=%b expected alu=%b lsu=%b", i, alu_ready, lsu_ready, exp_alu, !exp_alu); end
            @(posedge clk); #1;
            n_checks++; if (WE3 !== 1'b1 || A3 !== (exp_alu ? 5'd3 : 5'd4) || WD3 !== (exp_alu ? 32'hA1A1_0003 : 32'hB2B2_0004)) begin
                n_fail++; $display("FAIL rr_write[%0d]: got we3=%b a3=%0d wd3=%h expected we3=1 a3=%0d", i, WE3, A3, WD3, exp_alu ? 3 : 4);
            end
            exp_alu = !exp_alu;
            @(negedge clk);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_raw_hazard();
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd5; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
        #1;
        n_checks++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL raw_first_issue: got %b expected 0", issue_stall); end
        @(negedge clk);
        issue_rd = 5'd0; issue_rs1 = 5'd5;
        #1;
        n_checks++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b expected 1", issue_stall); end
        n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL raw_idle: got %b expected 0", idle); end
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_AAAA;
        #1;
        n_checks++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_accept: got %b expected 1", issue_stall); end
        @(posedge clk); #1;
        n_checks++; if (WE3 !== 1'b1 || A3 !== 5'd5) begin n_fail++; $display("FAIL raw_write: got we3=%b a3=%0d expected we3=1 a3=5", WE3, A3); end
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        n_checks++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_we3_cycle: got %b expected 1", issue_stall); end
        @(negedge clk); #1;
        n_checks++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL raw_release: got %b expected 0", issue_stall); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL raw_idle_after: got %b expected 1", idle); end
        issue_valid = 1'b0; issue_rs1 = '0;
    endtask

    task automatic test_rd_zero();
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        issue_valid = 1'b0; issue_rd = '0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready: got %b expected 1", alu_ready); end
        @(posedge clk); #1;
        n_checks++; if (WE3 !== 1'b0) begin n_fail++; $display("FAIL rd0_we3: got %b expected 0", WE3); end
        @(negedge clk);
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rs2 = 5'd9;
        #1;
        n_checks++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL rd0_busy_kept: got %b expected 1", issue_stall); end
        issue_valid = 1'b0; issue_rs2 = '0;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h0000_0999;
        #1;
        n_checks++; if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin n_fail++; $display("FAIL lsu_lone_grant: got lsu=%b alu=%b expected lsu=1 alu=0", lsu_ready, alu_ready); end
        @(posedge clk); #1;
        n_checks++; if (WE3 !== 1'b1 || A3 !== 5'd9 || WD3 !== 32'h0000_0999) begin n_fail++; $display("FAIL lsu_write: got we3=%b a3=%0d wd3=%h expected we3=1 a3=9 wd3=00000999", WE3, A3, WD3); end
        @(negedge clk);
        lsu_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rd0_idle_after: got %b expected 1", idle); end
    endtask

    task automatic test_waw();
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd6;
        #1;
        n_checks++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL waw_first: got %b expected 0", issue_stall); end
        @(negedge clk); #1;
        n_checks++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %b expected 1", issue_stall); end
        issue_valid = 1'b0; issue_rd = '0;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h6666_6666;
        @(negedge clk);
        alu_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL waw_single_clear: got %b expected 1", idle); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd7;
        @(negedge clk);
        issue_valid = 1'b0; issue_rd = '0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777_7777;
        @(posedge clk); #1;
        n_checks++; if (WE3 !== 1'b1) begin n_fail++; $display("FAIL arst_pending: got %b expected 1", WE3); end
        #2;
        rst = 1'b0;
        alu_valid = 1'b0;
        #1;
        n_checks++; if (WE3 !== 1'b0 || A3 !== 5'd0 || WD3 !== 32'h0) begin n_fail++; $display("FAIL arst_outputs: got we3=%b a3=%0d wd3=%h expected 0", WE3, A3, WD3); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL arst_idle: got %b expected 1", idle); end
        @(negedge clk);
        rst = 1'b1;
        issue_valid = 1'b1; issue_rs1 = 5'd7;
        #1;
        n_checks++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL arst_busy_cleared: got %b expected 0", issue_stall); end
        issue_valid = 1'b0; issue_rs1 = '0;
        // last_grant is back to LSU, so ALU takes the tie.
        alu_valid = 1'b1; alu_rd = 5'd3; lsu_valid = 1'b1; lsu_rd = 5'd4;
        #1;
        n_checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin n_fail++; $display("FAIL arst_first_tie: got alu=%b lsu=%b expected alu=1 lsu=0", alu_ready, lsu_ready); end
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_raw_hazard();
        test_rd_zero();
        test_waw();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
